// File: rtl/counter_stim_if.sv
// Command channel into the counter stimulus driver: valid/ready handshake
// carrying an opcode, a load value and a repeat count.
interface counter_stim_if #(
   parameter int WIDTH = 4,
   parameter int RPT_W = 8
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [WIDTH-1:0] cmd_data;
   logic [RPT_W-1:0] cmd_rpt;

   modport master (
      output cmd_valid, cmd_op, cmd_data, cmd_rpt,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, cmd_rpt,
      output cmd_ready
   );
endinterface

// File: rtl/counter_stim_driver.sv
// Drives load/updown/data of an up/down counter from queued-free commands and
// keeps exp_count, a cycle-accurate prediction of the counter value.
//
// state | meaning
// IDLE  | ready for a command; counter held by reloading exp_count
// RUN   | latched op driven for rem+1 cycles; cmd_* ignored
module counter_stim_driver #(
   parameter int WIDTH = 4,
   parameter int RPT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   counter_stim_if.slave    cmd,
   output logic             load,
   output logic             updown,
   output logic [WIDTH-1:0] data,
   output logic [WIDTH-1:0] exp_count,
   output logic             busy,
   output logic             done
);

   typedef enum logic {IDLE, RUN} state_e;
   typedef enum logic [1:0] {OP_UP, OP_DOWN, OP_LOAD, OP_TOGGLE} op_e;

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [RPT_W-1:0] rem_q, rem_d;
   logic             phase_q, phase_d;
   logic [WIDTH-1:0] exp_q, exp_d;
   logic             done_q, done_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= OP_UP;
         data_q  <= '0;
         rem_q   <= '0;
         phase_q <= 1'b1;
         exp_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         data_q  <= data_d;
         rem_q   <= rem_d;
         phase_q <= phase_d;
         exp_q   <= exp_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      data_d        = data_q;
      rem_d         = rem_q;
      phase_d       = phase_q;
      exp_d         = exp_q;
      done_d        = 1'b0;
      cmd.cmd_ready = 1'b0;
      busy          = 1'b0;
      load          = 1'b1;
      updown        = 1'b0;
      data          = exp_q;

      case (state_q)
         IDLE: begin
            cmd.cmd_ready = 1'b1;
            if (cmd.cmd_valid) begin
               op_d    = op_e'(cmd.cmd_op);
               data_d  = cmd.cmd_data;
               rem_d   = cmd.cmd_rpt;
               phase_d = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            case (op_q)
               OP_UP:     begin load = 1'b0; updown = 1'b1; end
               OP_DOWN:   begin load = 1'b0; updown = 1'b0; end
               OP_LOAD:   begin load = 1'b1; data = data_q; end
               OP_TOGGLE: begin load = 1'b0; updown = phase_q; end
               default:   begin load = 1'b1; end
            endcase
            phase_d = ~phase_q;
            if (rem_q == '0) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else begin
               rem_d = rem_q - 1'b1;
            end
            // Mirror exactly what the counter samples at this edge
            if (load)
               exp_d = data;
            else if (updown)
               exp_d = exp_q + ONE;
            else
               exp_d = exp_q - ONE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign exp_count = exp_q;
   assign done      = done_q;

endmodule
